// File: rtl/timer_pkg.sv
// Shared definitions for the game timer: FSM encoding, BCD limits and
// the active-low seven-segment table.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_MAXED  = 2'd3
  } state_t;

  localparam logic [7:0] SEC_LIMIT = 8'h59;
  localparam logic [7:0] MIN_LIMIT = 8'h99;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit 0 = segment a, bit 6 = segment g.
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    logic [6:0] p;
    case (code)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control requests into, and time/display outputs out of, the game timer.
interface game_timer_if;
  logic       sec_tick;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       running;
  logic       timeout;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output sec_tick, start, pause, clear,
    input  sec_bcd, min_bcd, running, timeout, an, seg, dp
  );

  modport slave (
    input  sec_tick, start, pause, clear,
    output sec_bcd, min_bcd, running, timeout, an, seg, dp
  );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver for an MM.SS BCD time value;
// all display outputs are registered one cycle after the digit select.
module seg_scan
  import timer_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] time_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  logic [SCAN_BITS-1:0] scan_q;
  logic [1:0]           sel;
  logic [3:0]           nibble;
  logic [3:0]           an_d, an_q;
  logic [6:0]           seg_d, seg_q;
  logic                 dp_d, dp_q;

  assign sel = scan_q[SCAN_BITS-1 -: 2];

  always_comb begin
    nibble = time_i[3:0];
    case (sel)
      2'd0: nibble = time_i[3:0];
      2'd1: nibble = time_i[7:4];
      2'd2: nibble = time_i[11:8];
      2'd3: nibble = time_i[15:12];
      default: nibble = time_i[3:0];
    endcase
    an_d  = ~(4'b0001 << sel);
    seg_d = seg_pattern(nibble);
    dp_d  = (sel != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_q <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      scan_q <= scan_q + SCAN_BITS'(1);
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: rtl/game_timer.sv
// MM:SS BCD game timer counting 1 s strobes, saturating at 99:59.
//   state  | meaning
//   IDLE   | zeroed, waiting for start
//   RUN    | counting tick edges
//   PAUSED | time held, start resumes
//   MAXED  | saturated at 99:59, only clear/reset leaves
module game_timer
  import timer_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic         clk,
  input  logic         reset,
  game_timer_if.slave  bus
);

  state_t     state_q, state_d;
  logic       tick_q;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       timeout_q, timeout_d;
  logic       tick_edge, count_en, at_max;

  assign tick_edge = bus.sec_tick & ~tick_q;
  assign count_en  = tick_edge && (state_q == ST_RUN);
  assign at_max    = (sec_q == SEC_LIMIT) && (min_q == MIN_LIMIT);

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      sec_d   = 8'h00;
      min_d   = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.start && !bus.pause) state_d = ST_RUN;
        ST_RUN: begin
          if (count_en && at_max) state_d = ST_MAXED;
          else if (bus.pause)     state_d = ST_PAUSED;
        end
        ST_PAUSED: if (bus.start && !bus.pause) state_d = ST_RUN;
        ST_MAXED:  state_d = ST_MAXED;
        default:   state_d = ST_IDLE;
      endcase
      // Saturation: a counted edge at 99:59 leaves the time untouched.
      if (count_en && !at_max) begin
        if (sec_q == SEC_LIMIT) begin
          sec_d = 8'h00;
          min_d = bcd_inc(min_q);
        end else begin
          sec_d = bcd_inc(sec_q);
        end
      end
    end
    timeout_d = (state_d == ST_MAXED) && (state_q != ST_MAXED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= 1'b0;
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= bus.sec_tick;
      sec_q     <= sec_d;
      min_q     <= min_d;
      timeout_q <= timeout_d;
    end
  end

  seg_scan #(.SCAN_BITS(SCAN_BITS)) u_seg_scan (
    .clk    (clk),
    .reset  (reset),
    .time_i ({min_q, sec_q}),
    .an_o   (bus.an),
    .seg_o  (bus.seg),
    .dp_o   (bus.dp)
  );

  assign bus.sec_bcd = sec_q;
  assign bus.min_bcd = min_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.timeout = timeout_q;

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 17, the width of the display refresh counter.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic sits on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port sec_tick, input, 1 bit: 1 s strobe from the upstream millisecond counter.
REQ-005 SHALL have port start, input, 1 bit: level request to begin or resume counting.
REQ-006 SHALL have port pause, input, 1 bit: level request to halt counting.
REQ-007 SHALL have port clear, input, 1 bit: level request to zero the time and return to IDLE.
REQ-008 SHALL have port sec_bcd, output, 8 bits: seconds as two BCD digits, 00-59.
REQ-009 SHALL have port min_bcd, output, 8 bits: minutes as two BCD digits, 00-99.
REQ-010 SHALL have port running, output, 1 bit: high while in state RUN.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse on entry to MAXED.
REQ-012 SHALL have port an, output, 4 bits: active-low digit enables; an[3] = minutes tens.
REQ-013 SHALL have port seg, output, 7 bits: active-low segments, seg[0]=a through seg[6]=g.
REQ-014 SHALL have port dp, output, 1 bit: active-low decimal point.

Function
REQ-015 SHALL detect a sec_tick rising edge with a registered copy; a level held high counts once.
REQ-016 SHALL implement the FSM states IDLE, RUN, PAUSED and MAXED.
REQ-017 SHALL make these transitions: IDLE->RUN on start; PAUSED->RUN on start; RUN->PAUSED on pause; RUN->MAXED on a counted edge at 99:59.
REQ-018 SHALL send any state to IDLE on clear, zeroing sec_bcd and min_bcd in the same edge.
REQ-019 SHALL resolve simultaneous requests with priority clear > pause > start; start with pause together in RUN gives PAUSED.
REQ-020 SHALL count a tick edge only when the current (pre-update) state is RUN, so a tick coinciding with pause in RUN is counted.
REQ-021 SHALL increment in BCD: seconds units 9->0 carries to tens; seconds 59->00 carries to minutes; minutes units 9->0 carries to minutes tens.
REQ-022 SHALL hold the time at 99:59 on a counted edge at 99:59, enter MAXED and assert timeout for exactly one cycle.
REQ-023 SHALL ignore start, pause and ticks in MAXED; only clear or reset leaves it.
REQ-024 SHALL never produce a non-BCD digit, a seconds value above 59, or a minutes value above 99.
REQ-025 SHALL use a free-running SCAN_BITS counter whose top two bits select digit 0-3 (0 = seconds units).
REQ-026 SHALL drive an, seg and dp registered: one cycle of latency from the digit select, with one an bit low at a time.
REQ-027 SHALL decode hex 0-9 to the standard pattern and show any other code as blank (all seg high).
REQ-028 SHALL drive dp low only while digit 2 is selected, forming the MM.SS separator.

Reset
REQ-029 SHALL on reset low set state IDLE, sec_bcd=00, min_bcd=00, running=0, timeout=0, the scan counter 0, an=4'b1111, seg=7'h7F, dp=1, and the tick register 0.
REQ-030 SHALL let reset override all inputs, including mid-count and MAXED, and discard a tick edge pending at reset release.

Structure
REQ-031 SHALL take the FSM state encoding, the BCD limit constants (59, 99) and the seven-segment pattern table from the shared package timer_pkg.
REQ-032 SHALL place the digit multiplexing and decoding in one sub-module, seg_scan, which takes the 16-bit time and returns an, seg and dp.

Verification
REQ-033 SHALL cover reset then start then 61 sec_tick pulses -> min_bcd=01, sec_bcd=01, running=1.
REQ-034 SHALL cover 3 ticks in RUN, then pause with a tick in the same cycle, then 5 more ticks -> 00:04, state PAUSED, running=0.
REQ-035 SHALL cover preloading to 99:58 via ticks in RUN, then 2 ticks -> 99:59, timeout high exactly one cycle, then 3 ticks and start -> still 99:59.
REQ-036 SHALL cover sec_tick held high 10 cycles in RUN -> exactly one increment.
REQ-037 SHALL cover clear, pause and start asserted together at 00:12 in RUN -> IDLE at 00:00, running=0.
REQ-038 SHALL cover SCAN_BITS=4 at time 12:34 -> an cycles 1110,1101,1011,0111 with seg patterns for 4,3,2,1 and dp low only with 1011.
